// File: rtl/ltpi_data_channel_requester.sv
// rtl/ltpi_data_channel_requester.sv - LTPI data channel initiator, one outstanding read/write
//
// Purpose: turns a local command/response port into LTPI data channel
// requests. It raises req_valid toward the PHY and waits for req_ack. It also
// waits for the matching single-cycle completion on resp_valid. When both
// have been seen, or the timeout expires, it emits a one-cycle rsp_valid.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  local command handshake
//   cmd_write/addr/...   command fields (write flag, address, data, byte enables)
//   rsp_valid            one-cycle completion pulse toward the local side
//   rsp_rdata            read data (0 for writes and timeouts)
//   rsp_error            non-zero operation_status, or timeout
//   rsp_timeout          completion produced by the timeout
//   busy                 a transaction is outstanding
//   stray_cnt            saturating count of discarded completions
//   req_valid/req_ack    four-phase request handshake toward the PHY
//   req                  request payload
//   resp_valid/resp      completion strobe and payload from the PHY

package ltpi_data_channel_pkg;

  typedef enum logic [7:0] {
    READ_REQ   = 8'h00,
    WRITE_REQ  = 8'h01,
    READ_COMP  = 8'h02,
    WRITE_COMP = 8'h03
  } dc_command_t;

  typedef struct packed {
    logic [7:0]      tag;
    dc_command_t     command;
    logic [3:0][7:0] address;
    logic [3:0][7:0] data;
    logic [3:0]      byte_en;
    logic [7:0]      operation_status;
  } Data_channel_payload_t;

endpackage

module ltpi_data_channel_requester
  import ltpi_data_channel_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_byte_en,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [7:0]            stray_cnt,
  output logic                  req_valid,
  input  logic                  req_ack,
  output Data_channel_payload_t req,
  input  logic                  resp_valid,
  input  Data_channel_payload_t resp
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  // Timeout fires when the counter holds this value on an edge.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [7:0]      tag_cnt;
  logic            ack_seen;
  logic            resp_seen;
  logic [3:0][7:0] cap_data;
  logic [7:0]      cap_status;
  logic [15:0]     tmo_cnt;

  logic            in_flight;
  logic            cur_write;
  dc_command_t     exp_comp;
  logic            resp_match;
  logic            ack_now;
  logic            resp_now;
  logic [3:0][7:0] fin_data;
  logic [7:0]      fin_status;
  logic            unused_resp_fields;

  // "_now" terms fold this edge's ack/match into the sticky flags so a
  // completion on the deciding edge is not lost to a one-cycle delay, and a
  // match on the timeout edge still counts as a normal completion.
  always_comb begin
    in_flight  = (state == REQ) || (state == WAIT_RESP);
    cur_write  = (req.command == WRITE_REQ);
    exp_comp   = cur_write ? WRITE_COMP : READ_COMP;
    resp_match = in_flight && resp_valid && !resp_seen &&
                 (resp.tag == req.tag) && (resp.command == exp_comp);
    ack_now    = ack_seen || ((state == REQ) && req_ack);
    resp_now   = resp_seen || resp_match;
    fin_data   = resp_match ? resp.data : cap_data;
    fin_status = resp_match ? resp.operation_status : cap_status;
  end

  assign unused_resp_fields = ^{resp.address, resp.byte_en};

  // A new request is never offered while the PHY still holds the previous ack.
  assign cmd_ready = (state == IDLE) && !req_ack;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tag_cnt     <= '0;
      ack_seen    <= 1'b0;
      resp_seen   <= 1'b0;
      cap_data    <= '0;
      cap_status  <= '0;
      tmo_cnt     <= '0;
      req         <= '0;
      req_valid   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      stray_cnt   <= '0;
    end else begin
      // Anything on resp_valid that is not the expected completion is dropped.
      if (resp_valid && !resp_match && (stray_cnt != 8'hFF)) begin
        stray_cnt <= stray_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            req.tag              <= tag_cnt;
            req.command          <= cmd_write ? WRITE_REQ : READ_REQ;
            req.address          <= cmd_addr;
            req.data             <= cmd_write ? cmd_wdata : 32'h0;
            req.byte_en          <= cmd_byte_en;
            req.operation_status <= '0;
            req_valid            <= 1'b1;
            ack_seen             <= 1'b0;
            resp_seen            <= 1'b0;
            tmo_cnt              <= '0;
            state                <= REQ;
          end
        end

        REQ, WAIT_RESP: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if ((state == REQ) && req_ack) begin
            ack_seen  <= 1'b1;
            req_valid <= 1'b0;
          end
          if (resp_match) begin
            resp_seen  <= 1'b1;
            cap_data   <= resp.data;
            cap_status <= resp.operation_status;
          end

          if (ack_now && resp_now) begin
            state       <= DONE;
            req_valid   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= cur_write ? 32'h0 : fin_data;
            rsp_error   <= (fin_status != 8'h00);
            rsp_timeout <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= DONE;
            req_valid   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
          end else if ((state == REQ) && req_ack) begin
            state <= WAIT_RESP;
          end
        end

        DONE: begin
          // Advancing the tag here also turns a late completion for a
          // timed-out transaction into a stray.
          rsp_valid   <= 1'b0;
          rsp_rdata   <= '0;
          rsp_error   <= 1'b0;
          rsp_timeout <= 1'b0;
          tag_cnt     <= tag_cnt + 8'd1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltpi_data_channel_requester.sv
// tb/tb_ltpi_data_channel_requester.sv - self-checking bench for ltpi_data_channel_requester
module tb_ltpi_data_channel_requester;
  import ltpi_data_channel_pkg::*;

  localparam int TMO   = 16;
  localparam int NEVER = 1000;

  logic                  clk;
  logic                  reset_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [31:0]           cmd_addr;
  logic [31:0]           cmd_wdata;
  logic [3:0]            cmd_byte_en;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;
  logic                  rsp_timeout;
  logic                  busy;
  logic [7:0]            stray_cnt;
  logic                  req_valid;
  logic                  req_ack;
  Data_channel_payload_t req;
  logic                  resp_valid;
  Data_channel_payload_t resp;

  int checks = 0;
  int errors = 0;
  int tag_m  = 0;
  int stray_m = 0;

  ltpi_data_channel_requester #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_byte_en(cmd_byte_en),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout), .busy(busy), .stray_cnt(stray_cnt),
    .req_valid(req_valid), .req_ack(req_ack), .req(req),
    .resp_valid(resp_valid), .resp(resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic Data_channel_payload_t build_req(input bit wr, input logic [31:0] addr,
                                                      input logic [31:0] wdata, input logic [3:0] be,
                                                      input int tag);
    Data_channel_payload_t p;
    p = '0;
    p.tag = 8'(tag);
    p.command = wr ? WRITE_REQ : READ_REQ;
    for (int b = 0; b < 4; b++) begin
      p.address[b] = 8'((addr >> (8 * b)) & 32'hFF);
      p.data[b]    = wr ? 8'((wdata >> (8 * b)) & 32'hFF) : 8'h00;
    end
    p.byte_en = be;
    p.operation_status = 8'h00;
    return p;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // One transaction. PHY acks in cycles [a, a+h] after the accept edge, sends
  // the matching completion in cycle r and a non-matching one in cycle s.
  task automatic do_txn(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int a_cyc, input int h_cyc, input int r_cyc, input int s_cyc,
                        input logic [7:0] status, input logic [31:0] phy_data);
    Data_channel_payload_t exp_req;
    bit          tmo;
    bit          exp_err;
    bit          ack_drv;
    int          done_c;
    int          last_c;
    logic [31:0] exp_rdata;

    exp_req = build_req(wr, addr, wdata, be, tag_m);
    tmo     = !((a_cyc <= TMO - 1) && (r_cyc <= TMO - 1));
    done_c  = tmo ? TMO : (((a_cyc > r_cyc) ? a_cyc : r_cyc) + 1);
    last_c  = done_c;
    if (a_cyc != NEVER && a_cyc + h_cyc > last_c) last_c = a_cyc + h_cyc;
    if (r_cyc != NEVER && r_cyc > last_c) last_c = r_cyc;
    if (s_cyc != NEVER && s_cyc > last_c) last_c = s_cyc;
    last_c    = last_c + 1;
    exp_rdata = (tmo || wr) ? 32'h0 : phy_data;
    exp_err   = tmo || (status != 8'h00);
    if (s_cyc != NEVER) stray_m++;
    if (tmo && r_cyc != NEVER && r_cyc >= TMO) stray_m++;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_byte_en = be;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s cmd_ready_before_accept: got %b want 1", name, cmd_ready);
    end
    @(posedge clk);
    for (int k = 0; k <= last_c; k++) begin
      #1;
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      ack_drv   = (a_cyc != NEVER) && (k >= a_cyc) && (k <= a_cyc + h_cyc);
      req_ack   = ack_drv;
      resp_valid = 1'b0;
      resp.address = $urandom;
      resp.byte_en = 4'($urandom);
      if (k == r_cyc || k == s_cyc) begin
        resp_valid = 1'b1;
        resp.tag = 8'(tag_m);
        resp.command = wr ? WRITE_COMP : READ_COMP;
        resp.data = wr ? $urandom : phy_data;
        resp.operation_status = status;
        if (k == s_cyc) begin
          case ($urandom_range(0, 2))
            0:       resp.tag = 8'(tag_m + 1);
            1:       resp.command = wr ? READ_COMP : WRITE_COMP;
            default: resp.command = wr ? WRITE_REQ : READ_REQ;
          endcase
        end
      end
      #1;
      checks++;
      if (rsp_valid !== (k == done_c)) begin
        errors++; $display("FAIL %s rsp_valid cyc %0d: got %b want %b", name, k, rsp_valid, (k == done_c));
      end
      if (k == done_c) begin
        checks += 4;
        if (rsp_rdata !== exp_rdata) begin
          errors++; $display("FAIL %s rsp_rdata: got %h want %h", name, rsp_rdata, exp_rdata);
        end
        if (rsp_error !== exp_err) begin
          errors++; $display("FAIL %s rsp_error: got %b want %b", name, rsp_error, exp_err);
        end
        if (rsp_timeout !== tmo) begin
          errors++; $display("FAIL %s rsp_timeout: got %b want %b", name, rsp_timeout, tmo);
        end
        if (cmd_ready !== 1'b0) begin
          errors++; $display("FAIL %s cmd_ready_in_done: got %b want 0", name, cmd_ready);
        end
      end else if (k < done_c) begin
        checks += 3;
        if (req !== exp_req) begin
          errors++; $display("FAIL %s req cyc %0d: got %h want %h", name, k, req, exp_req);
        end
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy cyc %0d: got %b want 1", name, k, busy);
        end
        if (req_valid !== ((k <= a_cyc) && (k <= TMO - 1))) begin
          errors++; $display("FAIL %s req_valid cyc %0d: got %b want %b", name, k, req_valid,
                             ((k <= a_cyc) && (k <= TMO - 1)));
        end
      end else begin
        checks += 2;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL %s busy_after cyc %0d: got %b want 0", name, k, busy);
        end
        if (cmd_ready !== !ack_drv) begin
          errors++; $display("FAIL %s cmd_ready cyc %0d: got %b want %b", name, k, cmd_ready, !ack_drv);
        end
      end
      @(posedge clk);
    end
    #1;
    req_ack = 1'b0; resp_valid = 1'b0;
    #1;
    checks++;
    if (stray_cnt !== 8'(sat255(stray_m))) begin
      errors++; $display("FAIL %s stray_cnt: got %0d want %0d", name, stray_cnt, sat255(stray_m));
    end
    tag_m = (tag_m + 1) % 256;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_byte_en = '0; req_ack = 1'b0; resp_valid = 1'b0; resp = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 9;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL reset req_valid: got %b want 0", req_valid); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset rsp_rdata: got %h want 0", rsp_rdata); end
    if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset rsp_error: got %b want 0", rsp_error); end
    if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset rsp_timeout: got %b want 0", rsp_timeout); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (stray_cnt !== 8'h0) begin errors++; $display("FAIL reset stray_cnt: got %0d want 0", stray_cnt); end
    if (req !== '0) begin errors++; $display("FAIL reset req: got %h want 0", req); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
    req_ack = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset cmd_ready_ack: got %b want 0", cmd_ready); end
    req_ack = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_write();
    do_txn("write", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1, 0, NEVER, 8'h00, 32'h0);
  endtask

  task automatic test_read();
    do_txn("read", 1'b0, 32'h10, 32'h0, 4'h5, 1, 1, 2, NEVER, 8'h00, 32'h00AD00EF);
  endtask

  task automatic test_resp_before_ack();
    do_txn("resp_before_ack", 1'b0, 32'h24, 32'h0, 4'hF, 3, 4, 0, NEVER, 8'h00, 32'h12345678);
  endtask

  task automatic test_error_status();
    do_txn("error_status", 1'b1, 32'h2000, 32'hCAFEF00D, 4'hF, 1, 0, 1, NEVER, 8'h01, 32'h0);
  endtask

  task automatic test_timeout();
    do_txn("timeout", 1'b0, 32'h80, 32'h0, 4'hF, NEVER, 0, 18, NEVER, 8'h00, 32'h55AA55AA);
  endtask

  task automatic test_timeout_edge();
    do_txn("match_on_timeout_edge", 1'b0, 32'h84, 32'h0, 4'h3, 15, 1, 15, NEVER, 8'h00, 32'hA1B2C3D4);
    do_txn("ack_only_on_timeout_edge", 1'b1, 32'h88, 32'h01020304, 4'hC, 15, 1, NEVER, NEVER, 8'h00, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int a, h, r, s, done;
      logic [7:0] st;
      a = $urandom_range(0, 10);
      h = $urandom_range(0, 3);
      r = $urandom_range(0, 10);
      done = ((a > r) ? a : r) + 1;
      s = ($urandom_range(0, 1) == 0) ? NEVER : int'($urandom_range(0, done - 1));
      if (s == r) s = NEVER;
      st = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_txn("random", 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
             a, h, r, s, st, $urandom);
    end
  endtask

  task automatic test_stray_idle();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      resp_valid = 1'b1; resp.tag = 8'(tag_m); resp.command = READ_COMP;
      stray_m++;
    end
    @(posedge clk); #1;
    resp_valid = 1'b0;
    #1;
    checks++;
    if (stray_cnt !== 8'(sat255(stray_m))) begin
      errors++; $display("FAIL stray_idle stray_cnt: got %0d want %0d", stray_cnt, sat255(stray_m));
    end
  endtask

  task automatic test_reset_midflight();
    int old_tag;
    old_tag = tag_m;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = $urandom; cmd_byte_en = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0; req_ack = 1'b1;
    @(posedge clk); #1;
    req_ack = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || req_valid !== 1'b0) begin
      errors++; $display("FAIL midflight wait_resp: got busy=%b req_valid=%b want 1/0", busy, req_valid);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL midflight req_valid: got %b want 0", req_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midflight busy: got %b want 0", busy); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midflight rsp_valid: got %b want 0", rsp_valid); end
    if (req !== '0) begin errors++; $display("FAIL midflight req: got %h want 0", req); end
    if (stray_cnt !== 8'h0) begin errors++; $display("FAIL midflight stray_cnt: got %0d want 0", stray_cnt); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tag_m = 0; stray_m = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      resp_valid = (k == 1);
      resp.tag = 8'(old_tag); resp.command = READ_COMP; resp.operation_status = 8'h00;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midflight no_rsp cyc %0d: got rsp_valid=%b busy=%b want 0/0", k, rsp_valid, busy);
      end
    end
    resp_valid = 1'b0;
    stray_m = 1;
    @(posedge clk); #2;
    checks++;
    if (stray_cnt !== 8'd1) begin
      errors++; $display("FAIL midflight late_stray: got %0d want 1", stray_cnt);
    end
    do_txn("after_reset_tag0", 1'b1, 32'h44, 32'h0BADF00D, 4'hF, 0, 0, 1, NEVER, 8'h00, 32'h0);
  endtask

  task automatic test_stray_saturate();
    @(posedge clk); #1;
    resp_valid = 1'b1; resp.tag = 8'hEE; resp.command = WRITE_REQ;
    repeat (300) @(posedge clk);
    #1;
    resp_valid = 1'b0;
    stray_m += 300;
    #1;
    checks++;
    if (stray_cnt !== 8'd255) begin
      errors++; $display("FAIL stray_saturate: got %0d want 255", stray_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_resp_before_ack();
    test_error_status();
    test_timeout();
    test_timeout_edge();
    test_random();
    test_stray_idle();
    test_reset_midflight();
    test_stray_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
